stream_demux: RTL and testbench

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux.sv | 131 +++++++++++++
 tb/tb_stream_demux.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// stream_demux: routes one input stream to one of two output channels.
// Each channel owns a one-entry holding register governed by an
// EMPTY/FULL FSM. A full channel whose sink is ready can be drained and
// refilled on the same edge.
// Optional build macro STREAM_DEMUX_COUNT_EN adds per-channel 16-bit
// counters of completed output transfers (cnt0, cnt1).
module stream_demux #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready
`ifdef STREAM_DEMUX_COUNT_EN
   ,
   output logic [15:0]      cnt0,
   output logic [15:0]      cnt1
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ch_state_t;

   ch_state_t        state_r     [2];
   ch_state_t        state_nxt_s [2];
   logic [WIDTH-1:0] data_r      [2];
   logic [1:0]       ch_ready_s;
   logic [1:0]       load_s;
   logic [1:0]       drain_s;

   assign ch_ready_s = {out1_ready, out0_ready};

   // Input acceptance: the selected channel must be empty or draining now.
   always_comb begin
      in_ready = 1'b0;
      load_s   = 2'b00;
      if (rst) begin
         in_ready = 1'b0;
      end else begin
         if (in_sel) begin
            in_ready = (state_r[1] == EMPTY) || out1_ready;
         end else begin
            in_ready = (state_r[0] == EMPTY) || out0_ready;
         end
      end
      load_s[0] = in_valid & in_ready & ~in_sel;
      load_s[1] = in_valid & in_ready &  in_sel;
   end

   // Per-channel next state: a load always leaves the channel FULL,
   // otherwise a ready sink empties it.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_nxt_s[i] = state_r[i];
         drain_s[i]     = (state_r[i] == FULL) && ch_ready_s[i];
         case (state_r[i])
            EMPTY: begin
               if (load_s[i]) begin
                  state_nxt_s[i] = FULL;
               end else begin
                  state_nxt_s[i] = EMPTY;
               end
            end
            FULL: begin
               if (load_s[i]) begin
                  state_nxt_s[i] = FULL;
               end else if (ch_ready_s[i]) begin
                  state_nxt_s[i] = EMPTY;
               end else begin
                  state_nxt_s[i] = FULL;
               end
            end
            default: begin
               state_nxt_s[i] = EMPTY;
            end
         endcase
      end
   end

   // Channel state and holding registers; data holds its last value when empty.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            state_r[i] <= EMPTY;
            data_r[i]  <= '0;
         end else begin
            state_r[i] <= state_nxt_s[i];
            if (load_s[i]) begin
               data_r[i] <= in_data;
            end
         end
      end
   end

   assign out0_data  = data_r[0];
   assign out1_data  = data_r[1];
   assign out0_valid = (state_r[0] == FULL);
   assign out1_valid = (state_r[1] == FULL);

`ifdef STREAM_DEMUX_COUNT_EN
   logic [15:0] cnt_r [2];

   // Completed output transfers per channel, wrapping naturally at 16 bits.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            cnt_r[i] <= 16'h0000;
         end else if (drain_s[i]) begin
            cnt_r[i] <= cnt_r[i] + 16'h0001;
         end
      end
   end

   assign cnt0 = cnt_r[0];
   assign cnt1 = cnt_r[1];
`else
   logic unused_drain_s;
   assign unused_drain_s = ^drain_s;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: a reference model of both channels
// plus per-channel scoreboard queues of accepted words, compared at negedge.
module tb_stream_demux;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out1_valid;
   logic             out1_ready;
`ifdef STREAM_DEMUX_COUNT_EN
   logic [15:0]      cnt0;
   logic [15:0]      cnt1;
   logic [15:0]      m_cnt0;
   logic [15:0]      m_cnt1;
`endif

   int checks = 0;
   int errors = 0;

   logic             m_full0, m_full1;
   logic [WIDTH-1:0] m_data0, m_data1;
   logic [WIDTH-1:0] q0 [$];
   logic [WIDTH-1:0] q1 [$];

   stream_demux #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready)
`ifdef STREAM_DEMUX_COUNT_EN
      ,
      .cnt0       (cnt0),
      .cnt1       (cnt1)
`endif
   );

   always #5 clk = ~clk;

   // Count one comparison and report it when it differs.
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // Apply one cycle of stimulus, check outputs at negedge, advance the model.
   task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic r0, input logic r1, input logic rs);
      logic             exp_rdy;
      logic             acc;
      logic [WIDTH-1:0] w;
      in_valid   = v;
      in_sel     = s;
      in_data    = d;
      out0_ready = r0;
      out1_ready = r1;
      rst        = rs;
      @(negedge clk);
      exp_rdy = !rs && (s ? (!m_full1 || r1) : (!m_full0 || r0));
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      check("out0_valid", {31'd0, out0_valid}, {31'd0, m_full0});
      check("out1_valid", {31'd0, out1_valid}, {31'd0, m_full1});
      check("out0_data", {24'd0, out0_data}, {24'd0, m_data0});
      check("out1_data", {24'd0, out1_data}, {24'd0, m_data1});
`ifdef STREAM_DEMUX_COUNT_EN
      check("cnt0", {16'd0, cnt0}, {16'd0, m_cnt0});
      check("cnt1", {16'd0, cnt1}, {16'd0, m_cnt1});
`endif
      if (rs) begin
         m_full0 = 1'b0;
         m_full1 = 1'b0;
         m_data0 = '0;
         m_data1 = '0;
         q0.delete();
         q1.delete();
`ifdef STREAM_DEMUX_COUNT_EN
         m_cnt0 = 16'h0000;
         m_cnt1 = 16'h0000;
`endif
      end else begin
         acc = v && exp_rdy;
         if (m_full0 && r0) begin
            if (q0.size() == 0) begin
               check("deliver0_q", 32'd0, 32'd1);
            end else begin
               w = q0.pop_front();
               check("deliver0", {24'd0, out0_data}, {24'd0, w});
            end
`ifdef STREAM_DEMUX_COUNT_EN
            m_cnt0 = m_cnt0 + 16'h0001;
`endif
         end
         if (m_full1 && r1) begin
            if (q1.size() == 0) begin
               check("deliver1_q", 32'd0, 32'd1);
            end else begin
               w = q1.pop_front();
               check("deliver1", {24'd0, out1_data}, {24'd0, w});
            end
`ifdef STREAM_DEMUX_COUNT_EN
            m_cnt1 = m_cnt1 + 16'h0001;
`endif
         end
         m_full0 = (acc && !s) || (m_full0 && !r0);
         m_full1 = (acc &&  s) || (m_full1 && !r1);
         if (acc && !s) begin
            q0.push_back(d);
            m_data0 = d;
         end
         if (acc && s) begin
            q1.push_back(d);
            m_data1 = d;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      m_full0 = 1'b0;
      m_full1 = 1'b0;
      m_data0 = '0;
      m_data1 = '0;
`ifdef STREAM_DEMUX_COUNT_EN
      m_cnt0 = 16'h0000;
      m_cnt1 = 16'h0000;
`endif
      // Initial reset: model state is only trusted from the second cycle on,
      // so the first reset cycle's pre-reset outputs are not meaningful.
      in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
      out0_ready = 1'b0; out1_ready = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

      // Basic routing.
      cycle(1'b1, 1'b0, 8'h19, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 8'h2A, 1'b1, 1'b1, 1'b0);
      check("route0", {24'd0, out0_data}, 32'h19);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      check("route1", {24'd0, out1_data}, 32'h2A);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

      // Backpressure on out0, then same-edge drain and refill.
      cycle(1'b1, 1'b0, 8'h19, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("refill_data", {24'd0, out0_data}, 32'h33);
      check("refill_valid", {31'd0, out0_valid}, 32'd1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

      // Independent channels: out0 stalled, out1 still accepts.
      cycle(1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      check("indep0", {24'd0, out0_data}, 32'h44);
      check("indep1", {24'd0, out1_data}, 32'h2A);

      // Reset mid-operation with both channels full and an input offered.
      cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      check("rst_valid0", {31'd0, out0_valid}, 32'd0);
      check("rst_data1", {24'd0, out1_data}, 32'd0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (i == 200) ? 1'b1 : 1'b0);
      end

`ifdef STREAM_DEMUX_COUNT_EN
      // Counter wrap: exactly 65536 transfers on out1.
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 65536; i++) begin
         cycle(1'b1, 1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
      end
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      check("wrap_cnt1", {16'd0, cnt1}, 32'd0);
      check("wrap_cnt0", {16'd0, cnt0}, 32'd0);
`endif

      // Drain everything: every accepted word must have been delivered.
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      end
      check("left_q0", q0.size(), 32'd0);
      check("left_q1", q1.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
